iomem_fabric: RTL and testbench

Parametrised iomem-bus interconnect for the picosoc top level. It replaces the hand-written address if/else chain with a registered decoder and a request/ready handshake state machine. It serves NUM_EXT external peripheral slots (RNG, user RAM, and similar) plus one internal slot holding a GPIO register and a STATUS register. A per-access timeout returns ERR_DATA, and decode errors are recorded, so a stuck or missing peripheral cannot hang the CPU.

---
 rtl/iomem_fabric_pkg.sv | 26 ++
 rtl/iomem_fabric_regs.sv | 88 ++++++++
 rtl/iomem_fabric.sv | 172 +++++++++++++++++
 tb/tb_iomem_fabric.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_fabric_pkg.sv
// Shared types and constants for the picosoc iomem interconnect:
// FSM states, internal register map and STATUS bit layout.
package iomem_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte offsets of the internal registers inside slot 0
  localparam logic [31:0] GPIO_OFS   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_TO_BIT  = 0;
  localparam int STAT_DEC_BIT = 1;
  localparam int STAT_IDX_LSB = 8;

  // Slot 0 is internal, so NUM_EXT external slots need NUM_EXT+1 codes
  function automatic int calc_idxw(input int num_ext);
    int w;
    w = $clog2(num_ext + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iomem_fabric_regs.sv
// Internal slot register file: byte-lane writable GPIO register and a
// sticky STATUS register with write-1-to-clear error flags.
module iomem_fabric_regs
  import iomem_fabric_pkg::*;
#(
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              access,
  input  logic              gpio_sel,
  input  logic              status_sel,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  input  logic              set_timeout,
  input  logic              set_decode,
  input  logic [7:0]        timeout_idx,
  output logic [31:0]       rd_data,
  output logic [GPIO_W-1:0] gpio
);

  logic        to_flag;
  logic        dec_flag;
  logic [7:0]  to_idx;
  logic [31:0] gpio_ext;
  logic [31:0] status;
  logic        gpio_we;
  logic        status_we;
  logic        unused_bits;

  // Lanes above GPIO_W are simply not stored, so part of the bus is dropped
  assign unused_bits = ^{wdata, wstrb};

  assign gpio_we   = access & gpio_sel & (|wstrb);
  assign status_we = access & status_sel & wstrb[0];

  always_comb begin
    gpio_ext = '0;
    gpio_ext[GPIO_W-1:0] = gpio;
  end

  always_comb begin
    status = '0;
    status[STAT_TO_BIT]       = to_flag;
    status[STAT_DEC_BIT]      = dec_flag;
    status[STAT_IDX_LSB +: 8] = to_idx;
  end

  always_comb begin
    rd_data = '0;
    if (gpio_sel)
      rd_data = gpio_ext;
    else if (status_sel)
      rd_data = status;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio <= '0;
    end else if (gpio_we) begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (wstrb[i/8])
          gpio[i] <= wdata[i];
      end
    end
  end

  // A set and a clear never meet in one edge since only one access is in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_flag  <= 1'b0;
      dec_flag <= 1'b0;
      to_idx   <= '0;
    end else begin
      if (set_timeout) begin
        to_flag <= 1'b1;
        to_idx  <= timeout_idx;
      end else if (status_we && wdata[STAT_TO_BIT]) begin
        to_flag <= 1'b0;
      end
      if (set_decode)
        dec_flag <= 1'b1;
      else if (status_we && wdata[STAT_DEC_BIT])
        dec_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/iomem_fabric.sv
// picosoc iomem interconnect: registered slot decode, single-outstanding
// request/ready FSM with per-access timeout and decode-error reporting.
module iomem_fabric
  import iomem_fabric_pkg::*;
#(
  parameter int          NUM_EXT   = 2,
  parameter int          SLV_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
  parameter int          GPIO_W    = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  output logic [NUM_EXT-1:0]    s_valid,
  output logic [3:0]            s_wstrb,
  output logic [SLV_AW-1:0]     s_addr,
  output logic [31:0]           s_wdata,
  input  logic [NUM_EXT-1:0]    s_ready,
  input  logic [32*NUM_EXT-1:0] s_rdata,
  output logic [GPIO_W-1:0]     gpio_o
);

  localparam int IDXW = calc_idxw(NUM_EXT);
  localparam int HIW  = SLV_AW + IDXW;

  state_t              state, state_n;
  logic [IDXW-1:0]     req_idx;
  logic [IDXW-1:0]     sel_idx, sel_idx_n;
  logic [31:0]         cnt, cnt_n;
  logic                hit;
  logic                gpio_sel, status_sel;
  logic [NUM_EXT-1:0]  s_valid_n;
  logic [3:0]          s_wstrb_n;
  logic [SLV_AW-1:0]   s_addr_n;
  logic [31:0]         s_wdata_n;
  logic                ready_n;
  logic [31:0]         rdata_n;
  logic                reg_access, set_to, set_dec;
  logic [31:0]         reg_rdata;
  logic                slot_ready;
  logic [31:0]         slot_rdata;

  assign req_idx    = iomem_addr[SLV_AW +: IDXW];
  assign hit        = (iomem_addr[31:HIW] == BASE_ADDR[31:HIW]);
  assign gpio_sel   = (iomem_addr[SLV_AW-1:2] == GPIO_OFS[SLV_AW-1:2]);
  assign status_sel = (iomem_addr[SLV_AW-1:2] == STATUS_OFS[SLV_AW-1:2]);

  // Only the slot that owns the outstanding request may complete it
  always_comb begin
    slot_ready = 1'b0;
    slot_rdata = '0;
    for (int k = 0; k < NUM_EXT; k++) begin
      if (int'(sel_idx) == k + 1) begin
        slot_ready = s_ready[k];
        slot_rdata = s_rdata[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_n    = state;
    sel_idx_n  = sel_idx;
    cnt_n      = cnt;
    s_valid_n  = s_valid;
    s_wstrb_n  = s_wstrb;
    s_addr_n   = s_addr;
    s_wdata_n  = s_wdata;
    ready_n    = 1'b0;
    rdata_n    = iomem_rdata;
    reg_access = 1'b0;
    set_to     = 1'b0;
    set_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (iomem_valid && hit) begin
          if (req_idx == '0) begin
            reg_access = 1'b1;
            rdata_n    = reg_rdata;
            ready_n    = 1'b1;
            state_n    = RESP;
          end else if (int'(req_idx) <= NUM_EXT) begin
            for (int k = 0; k < NUM_EXT; k++)
              s_valid_n[k] = (int'(req_idx) == k + 1);
            s_wstrb_n = iomem_wstrb;
            s_addr_n  = iomem_addr[SLV_AW-1:0];
            s_wdata_n = iomem_wdata;
            sel_idx_n = req_idx;
            cnt_n     = '0;
            state_n   = WAIT;
          end else begin
            rdata_n = ERR_DATA;
            set_dec = 1'b1;
            ready_n = 1'b1;
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        // Slave completion takes priority over a timeout in the same cycle
        if (slot_ready) begin
          rdata_n   = slot_rdata;
          s_valid_n = '0;
          ready_n   = 1'b1;
          state_n   = RESP;
        end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
          rdata_n   = ERR_DATA;
          set_to    = 1'b1;
          s_valid_n = '0;
          ready_n   = 1'b1;
          state_n   = RESP;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      sel_idx     <= '0;
      cnt         <= '0;
      s_valid     <= '0;
      s_wstrb     <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      state       <= state_n;
      sel_idx     <= sel_idx_n;
      cnt         <= cnt_n;
      s_valid     <= s_valid_n;
      s_wstrb     <= s_wstrb_n;
      s_addr      <= s_addr_n;
      s_wdata     <= s_wdata_n;
      iomem_ready <= ready_n;
      iomem_rdata <= rdata_n;
    end
  end

  iomem_fabric_regs #(
    .GPIO_W (GPIO_W)
  ) u_regs (
    .clk         (clk),
    .resetn      (resetn),
    .access      (reg_access),
    .gpio_sel    (gpio_sel),
    .status_sel  (status_sel),
    .wstrb       (iomem_wstrb),
    .wdata       (iomem_wdata),
    .set_timeout (set_to),
    .set_decode  (set_dec),
    .timeout_idx (8'(sel_idx)),
    .rd_data     (reg_rdata),
    .gpio        (gpio_o)
  );

endmodule

// File: tb/tb_iomem_fabric.sv
// Self-checking bench for iomem_fabric: vector table, hand-written corner
// sequences and randomized accesses against a behavioural register/slot model.
module tb_iomem_fabric;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_a, valid_b;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic [1:0]  s_ready_a, s_ready_b;
  logic [63:0] s_rdata;

  logic        ready_a, ready_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  s_valid_a, s_valid_b;
  logic [3:0]  s_wstrb_a, s_wstrb_b;
  logic [11:0] s_addr_a, s_addr_b;
  logic [31:0] s_wdata_a, s_wdata_b;
  logic [7:0]  gpio_a, gpio_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iomem_fabric #(.TIMEOUT(255)) u_dut (
    .clk(clk), .resetn(resetn), .iomem_valid(valid_a), .iomem_ready(ready_a),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata_a),
    .s_valid(s_valid_a), .s_wstrb(s_wstrb_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a),
    .s_ready(s_ready_a), .s_rdata(s_rdata), .gpio_o(gpio_a)
  );

  // Short-timeout instance for the ready-versus-timeout race
  iomem_fabric #(.TIMEOUT(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid_b), .iomem_ready(ready_b),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata_b),
    .s_valid(s_valid_b), .s_wstrb(s_wstrb_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b),
    .s_ready(s_ready_b), .s_rdata(s_rdata), .gpio_o(gpio_b)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          rdy_at;
    logic [31:0] sdata;
    logic [31:0] exp_rd;
    int          exp_e;
    logic [1:0]  exp_sv;
    logic [11:0] exp_sa;
  } vec_t;

  vec_t vecs[13];

  logic [7:0] m_gpio;
  logic       m_to, m_dec;
  logic [7:0] m_idx;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gpio = '0;
    m_to   = 1'b0;
    m_dec  = 1'b0;
    m_idx  = '0;
  endtask

  // Expected outcome of one access, from the address map and timing rules
  task automatic model_access(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                              input int rdy_at, input logic [31:0] sd, input int tmo,
                              output bit exp_resp, output logic [31:0] exp_rd,
                              output int exp_e, output logic [1:0] exp_sv);
    int idx, word;
    exp_resp = 1'b1;
    exp_rd   = '0;
    exp_e    = 1;
    exp_sv   = 2'b00;
    idx  = int'((a >> 12) & 32'h3);
    word = int'((a & 32'hFFF) >> 2);
    if ((a >> 14) != (32'h0300_0000 >> 14)) begin
      exp_resp = 1'b0;
    end else if (idx == 0) begin
      if (word == 0) begin
        exp_rd = {24'h0, m_gpio};
        if (st[0]) m_gpio = d[7:0];
      end else if (word == 1) begin
        exp_rd = {16'h0, m_idx, 6'h0, m_dec, m_to};
        if (st[0]) begin
          if (d[0]) m_to = 1'b0;
          if (d[1]) m_dec = 1'b0;
        end
      end
    end else if (idx <= 2) begin
      exp_sv = 2'(1 << (idx - 1));
      if (rdy_at >= 0 && rdy_at + 2 <= tmo + 1) begin
        exp_rd = sd;
        exp_e  = rdy_at + 2;
      end else begin
        exp_rd = 32'hDEAD_BEEF;
        exp_e  = tmo + 1;
        m_to   = 1'b1;
        m_idx  = 8'(idx);
      end
    end else begin
      exp_rd = 32'hDEAD_BEEF;
      m_dec  = 1'b1;
    end
  endtask

  // One CPU access; edges counts the valid-sample edge as edge 1, 0 = no ready
  task automatic apply_stimulus(input bit dut_b, input logic [31:0] a, input logic [3:0] st,
                                input logic [31:0] d, input int rdy_at, input logic [31:0] sd,
                                input bit noise, input int max_e,
                                output logic [31:0] rd, output int edges,
                                output logic [1:0] sv_first, output logic [11:0] sa_first,
                                output logic [31:0] sw_first, output bit sv_seen);
    int slot;
    logic [1:0] cur_sv;
    slot  = int'(a[13:12]);
    addr  = a;
    wstrb = st;
    wdata = d;
    s_rdata = {~sd, ~sd};
    if (slot == 1) s_rdata[31:0] = sd;
    if (slot == 2) s_rdata[63:32] = sd;
    if (noise && !dut_b && (slot == 1 || slot == 2))
      s_ready_a[2 - slot] = 1'b1;
    if (dut_b) valid_b = 1'b1;
    else valid_a = 1'b1;
    rd = '0; edges = 0; sv_first = '0; sa_first = '0; sw_first = '0; sv_seen = 1'b0;
    for (int e = 1; e <= max_e; e++) begin
      @(posedge clk);
      #1;
      cur_sv = dut_b ? s_valid_b : s_valid_a;
      if (e == 1) begin
        sv_first = cur_sv;
        sa_first = dut_b ? s_addr_b : s_addr_a;
        sw_first = dut_b ? s_wdata_b : s_wdata_a;
      end
      if (cur_sv != 2'b00) sv_seen = 1'b1;
      if (dut_b ? ready_b : ready_a) begin
        edges = e;
        rd = dut_b ? rdata_b : rdata_a;
        break;
      end
      if (rdy_at >= 0 && e == rdy_at + 1 && (slot == 1 || slot == 2)) begin
        if (dut_b) s_ready_b[slot-1] = 1'b1;
        else s_ready_a[slot-1] = 1'b1;
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    s_ready_a = 2'b00;
    s_ready_b = 2'b00;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, sw, a, d, exp_rd;
    logic [1:0]  sv, exp_sv;
    logic [11:0] sa;
    logic [3:0]  st;
    int          edges, exp_e, kind, rdy_at;
    bit          seen, exp_resp, noise;

    vecs[0]  = '{32'h0300_0000, 4'h1, 32'h0000_00A5, -1, 32'h0,        32'h0000_0000, 1,   2'b00, 12'h000};
    vecs[1]  = '{32'h0300_0000, 4'h0, 32'h0,         -1, 32'h0,        32'h0000_00A5, 1,   2'b00, 12'h000};
    vecs[2]  = '{32'h0300_1004, 4'h0, 32'h0,          3, 32'h1234_5678, 32'h1234_5678, 5,  2'b01, 12'h004};
    vecs[3]  = '{32'h0300_2000, 4'h0, 32'h0,         -1, 32'h5555_0000, 32'hDEAD_BEEF, 256, 2'b10, 12'h000};
    vecs[4]  = '{32'h0300_0004, 4'h0, 32'h0,         -1, 32'h0,        32'h0000_0201, 1,   2'b00, 12'h000};
    vecs[5]  = '{32'h0300_0004, 4'h1, 32'h0000_0001, -1, 32'h0,        32'h0000_0201, 1,   2'b00, 12'h000};
    vecs[6]  = '{32'h0300_0004, 4'h0, 32'h0,         -1, 32'h0,        32'h0000_0200, 1,   2'b00, 12'h000};
    vecs[7]  = '{32'h0300_3000, 4'h0, 32'h0,         -1, 32'h0,        32'hDEAD_BEEF, 1,   2'b00, 12'h000};
    vecs[8]  = '{32'h0300_0004, 4'h0, 32'h0,         -1, 32'h0,        32'h0000_0202, 1,   2'b00, 12'h000};
    vecs[9]  = '{32'h0300_0008, 4'hF, 32'hFFFF_FFFF, -1, 32'h0,        32'h0000_0000, 1,   2'b00, 12'h000};
    vecs[10] = '{32'h0300_0000, 4'hE, 32'hFFFF_FF00, -1, 32'h0,        32'h0000_00A5, 1,   2'b00, 12'h000};
    vecs[11] = '{32'h0300_0000, 4'h0, 32'h0,         -1, 32'h0,        32'h0000_00A5, 1,   2'b00, 12'h000};
    vecs[12] = '{32'h0300_1010, 4'hF, 32'h1122_3344,  0, 32'hCAFE_0000, 32'hCAFE_0000, 2,  2'b01, 12'h010};

    resetn = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    wstrb = '0; addr = '0; wdata = '0;
    s_ready_a = '0; s_ready_b = '0; s_rdata = '0;
    model_reset();
    #12;
    check_output("reset ready", 32'(ready_a), 32'h0);
    check_output("reset rdata", rdata_a, 32'h0);
    check_output("reset s_valid", 32'(s_valid_a), 32'h0);
    check_output("reset s_addr", 32'(s_addr_a), 32'h0);
    check_output("reset s_wdata", s_wdata_a, 32'h0);
    check_output("reset gpio", 32'(gpio_a), 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      model_access(vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].rdy_at, vecs[i].sdata, 255,
                   exp_resp, exp_rd, exp_e, exp_sv);
      apply_stimulus(1'b0, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].rdy_at,
                     vecs[i].sdata, 1'b0, 262, rd, edges, sv, sa, sw, seen);
      check_output($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check_output($sformatf("vec%0d latency", i), 32'(edges), 32'(vecs[i].exp_e));
      check_output($sformatf("vec%0d s_valid", i), 32'(sv), 32'(vecs[i].exp_sv));
      if (vecs[i].exp_sv != 2'b00) begin
        check_output($sformatf("vec%0d s_addr", i), 32'(sa), 32'(vecs[i].exp_sa));
        check_output($sformatf("vec%0d s_wdata", i), sw, vecs[i].wdata);
      end
      if (i == 0) check_output("gpio after write", 32'(gpio_a), 32'h0000_00A5);
    end

    // Region miss: never answered, no slave request
    apply_stimulus(1'b0, 32'h0400_0000, 4'h0, 32'h0, -1, 32'h0, 1'b0, 10, rd, edges, sv, sa, sw, seen);
    check_output("miss ready", 32'(edges), 32'h0);
    check_output("miss s_valid", 32'(seen), 32'h0);

    // Asynchronous reset while a slave request is outstanding
    addr = 32'h0300_1000; wstrb = 4'h0; valid_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("pre-reset s_valid", 32'(s_valid_a), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("async reset s_valid", 32'(s_valid_a), 32'h0);
    check_output("async reset ready", 32'(ready_a), 32'h0);
    check_output("async reset gpio", 32'(gpio_a), 32'h0);
    valid_a = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'h0300_0000, 4'h1, 32'h0000_003C, -1, 32'h0, 1'b0, 10, rd, edges, sv, sa, sw, seen);
    check_output("post-reset gpio write rdata", rd, 32'h0);
    check_output("post-reset gpio write latency", 32'(edges), 32'h1);
    check_output("post-reset gpio", 32'(gpio_a), 32'h3C);
    m_gpio = 8'h3C;

    // TIMEOUT=4: ready on the final count wins, one later times out
    apply_stimulus(1'b1, 32'h0300_1000, 4'h0, 32'h0, 3, 32'h5A5A_1234, 1'b0, 12, rd, edges, sv, sa, sw, seen);
    check_output("race rdata", rd, 32'h5A5A_1234);
    check_output("race latency", 32'(edges), 32'h5);
    apply_stimulus(1'b1, 32'h0300_0004, 4'h0, 32'h0, -1, 32'h0, 1'b0, 12, rd, edges, sv, sa, sw, seen);
    check_output("race status", rd, 32'h0);
    apply_stimulus(1'b1, 32'h0300_1000, 4'h0, 32'h0, 4, 32'h5A5A_1234, 1'b0, 12, rd, edges, sv, sa, sw, seen);
    check_output("late ready rdata", rd, 32'hDEAD_BEEF);
    check_output("late ready latency", 32'(edges), 32'h5);
    apply_stimulus(1'b1, 32'h0300_0004, 4'h0, 32'h0, -1, 32'h0, 1'b0, 12, rd, edges, sv, sa, sw, seen);
    check_output("late ready status", rd, 32'h0000_0101);

    for (int n = 0; n < 40; n++) begin
      kind   = $urandom_range(0, 8);
      st     = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d      = $urandom;
      noise  = 1'($urandom_range(0, 1));
      rdy_at = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) rdy_at = -1;
      case (kind)
        0, 1: a = 32'h0300_0000;
        2:    a = 32'h0300_0004;
        3:    a = 32'h0300_0000 | (32'($urandom_range(2, 1023)) << 2);
        4, 5: a = 32'h0300_1000 | ($urandom & 32'hFFC);
        6:    a = 32'h0300_2000 | ($urandom & 32'hFFC);
        7:    a = 32'h0300_3000 | ($urandom & 32'hFFC);
        default: begin
          a = $urandom;
          if ((a >> 14) == (32'h0300_0000 >> 14)) a[31] = ~a[31];
        end
      endcase
      model_access(a, st, d, rdy_at, ~d, 255, exp_resp, exp_rd, exp_e, exp_sv);
      apply_stimulus(1'b0, a, st, d, rdy_at, ~d, noise, exp_resp ? 262 : 10,
                     rd, edges, sv, sa, sw, seen);
      if (exp_resp) begin
        check_output($sformatf("rand%0d rdata @%08h", n, a), rd, exp_rd);
        check_output($sformatf("rand%0d latency", n), 32'(edges), 32'(exp_e));
        check_output($sformatf("rand%0d s_valid", n), 32'(sv), 32'(exp_sv));
      end else begin
        check_output($sformatf("rand%0d miss ready", n), 32'(edges), 32'h0);
        check_output($sformatf("rand%0d miss s_valid", n), 32'(seen), 32'h0);
      end
    end
    check_output("final gpio", 32'(gpio_a), 32'(m_gpio));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
